rider_detect: RTL and testbench



---
 rtl/rider_detect.sv | 138 +++++++++++++
 tb/tb_rider_detect.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rider_detect.sv
// rider_detect: qualifies a balanced, stable rider from the two load cells and paces the A2D conversions.
// Latency: all outputs are registered and follow a load change by 1 clk; nxt pulses once every NXT_PERIOD clks.
// Backpressure: none; the loads are sampled on every clock and nxt is free-running.
// Ports: clk system clock; rst synchronous active-high reset;
//        lft_ld / rght_ld 12-bit unsigned load-cell readings;
//        nxt one-clock conversion request; en_steer rider present, balanced and stable;
//        rider_off no rider on the platform.
// Build option: define FAST_SIM_EN to shrink the stability timer to 15 bits (32767 clks) for simulation.
module rider_detect #(
   parameter logic [11:0] MIN_RIDER_WT = 12'h200,
   parameter logic [11:0] WT_HYST      = 12'h040,
   parameter int          NXT_PERIOD   = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   output logic        nxt,
   output logic        en_steer,
   output logic        rider_off
);

`ifdef FAST_SIM_EN
   localparam int TMR_W = 15;
`else
   localparam int TMR_W = 26;
`endif

   localparam int               NXT_W    = $clog2(NXT_PERIOD);
   localparam logic [NXT_W-1:0] NXT_LAST = NXT_W'(NXT_PERIOD - 1);
   localparam logic [12:0]      GONE_WT  = {1'b0, MIN_RIDER_WT - WT_HYST};

   typedef enum logic [1:0] {IDLE, WAIT, STEER} state_t;

   state_t           state;
   state_t           nxt_state;
   logic [TMR_W-1:0] tmr;
   logic [NXT_W-1:0] nxt_cnt;
   logic             clr_tmr;
   logic             inc_tmr;
   logic             tmr_full;

   logic [12:0] sum;
   logic [11:0] diff;
   logic [16:0] diff_x16;
   logic [16:0] sum_x15;
   logic        present;
   logic        gone;
   logic        diff_big;

   // Load arithmetic is purely combinational on the current readings.
   assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
   assign diff     = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
   // 17 bits holds both products in full: 4095*16 and 8190*15 both fit.
   assign diff_x16 = {1'b0, diff, 4'b0000};
   assign sum_x15  = {4'b0000, sum} * 17'd15;

   assign present  = (sum > {1'b0, MIN_RIDER_WT});
   assign gone     = (sum < GONE_WT);
   assign diff_big = (diff_x16 > sum_x15);
   assign tmr_full = &tmr;

   // Next-state logic. Between the gone and present thresholds an occupied
   // platform stays occupied, which gives the hysteresis.
   always_comb begin
      nxt_state = state;
      clr_tmr   = 1'b0;
      inc_tmr   = 1'b0;
      case (state)
         IDLE: begin
            if (present) begin
               nxt_state = WAIT;
               clr_tmr   = 1'b1;
            end
         end
         WAIT: begin
            if (gone) begin
               nxt_state = IDLE;
            end else if (diff_big) begin
               clr_tmr = 1'b1;
            end else if (tmr_full) begin
               nxt_state = STEER;
            end else begin
               inc_tmr = 1'b1;
            end
         end
         STEER: begin
            if (gone) begin
               nxt_state = IDLE;
            end else if (diff_big) begin
               nxt_state = WAIT;
               clr_tmr   = 1'b1;
            end
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   // State, timer and outputs. Outputs decode the next state so they move on
   // the same edge as the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tmr       <= '0;
         en_steer  <= 1'b0;
         rider_off <= 1'b1;
      end else begin
         state     <= nxt_state;
         en_steer  <= (nxt_state == STEER);
         rider_off <= (nxt_state == IDLE);
         if (clr_tmr) begin
            tmr <= '0;
         end else if (inc_tmr && !tmr_full) begin
            tmr <= tmr + 1'b1;
         end
      end
   end

   // Free-running conversion pacer: nxt is high for the clock after the
   // counter reaches its last value, so the first pulse lands NXT_PERIOD clks
   // after reset release.
   always_ff @(posedge clk) begin
      if (rst) begin
         nxt_cnt <= '0;
         nxt     <= 1'b0;
      end else begin
         nxt <= (nxt_cnt == NXT_LAST);
         if (nxt_cnt == NXT_LAST) begin
            nxt_cnt <= '0;
         end else begin
            nxt_cnt <= nxt_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rider_detect.sv
// tb_rider_detect: checks rider_detect against a cycle-level behavioural model plus directed vectors.
// Latency: model advances once per clk edge; DUT outputs are compared 1 time unit after each edge.
// Backpressure: not applicable; stimulus is applied every clock.
module tb_rider_detect;

`ifdef FAST_SIM_EN
   localparam longint TMR_MAX = 32767;
`else
   localparam longint TMR_MAX = 67108863;
`endif
   localparam int NXT_PERIOD = 2048;
   localparam int MIN_WT     = 512;
   localparam int GONE_WT    = 448;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic        nxt;
   logic        en_steer;
   logic        rider_off;

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model: rider on/off with hysteresis, steering flag, and a
   // count of consecutive stable balanced clocks.
   bit     m_on;
   bit     m_steer;
   longint m_run;
   int     m_cyc;
   bit     m_nxt;

   // Observed nxt pulse positions, in clocks since reset release.
   int rel_cyc;
   int nxt_q[$];

   rider_detect dut (
      .clk       (clk),
      .rst       (rst),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .nxt       (nxt),
      .en_steer  (en_steer),
      .rider_off (rider_off)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic model_step();
      int s, d;
      if (rst) begin
         m_on = 0; m_steer = 0; m_run = 0; m_cyc = 0; m_nxt = 0;
      end else begin
         s = int'(lft_ld) + int'(rght_ld);
         d = (lft_ld > rght_ld) ? int'(lft_ld) - int'(rght_ld) : int'(rght_ld) - int'(lft_ld);
         m_cyc++;
         m_nxt = (m_cyc % NXT_PERIOD == 0);
         if (!m_on) begin
            if (s > MIN_WT) begin
               m_on  = 1;
               m_run = 0;
            end
         end else if (s < GONE_WT) begin
            m_on    = 0;
            m_steer = 0;
         end else if (d * 16 > s * 15) begin
            m_steer = 0;
            m_run   = 0;
         end else if (!m_steer) begin
            if (m_run == TMR_MAX) m_steer = 1;
            else m_run++;
         end
      end
   endtask

   // One clock: advance model, then compare every output against it.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("cyc_rider_off", rider_off, !m_on);
      chk("cyc_en_steer", en_steer, m_steer);
      chk("cyc_nxt", nxt, m_nxt);
      if (rst) begin
         rel_cyc = 0;
         nxt_q.delete();
      end else begin
         rel_cyc++;
         if (nxt) nxt_q.push_back(rel_cyc);
      end
   endtask

   task automatic set_ld(input int l, input int r);
      lft_ld  = 12'(l);
      rght_ld = 12'(r);
   endtask

   task automatic wait_steer(input int max, output int n);
      n = 0;
      while (!en_steer && n < max) begin
         step();
         n++;
      end
   endtask

   typedef struct {
      logic [11:0] l;
      logic [11:0] r;
      logic        exp_off;
   } vec_t;

   initial begin
      vec_t vecs[7];
      int   n;
      int   hold;
      int   mode;
      int   base;

      vecs[0] = '{12'h000, 12'h000, 1'b1};
      vecs[1] = '{12'h100, 12'h100, 1'b1};  // sum 0x200: not above threshold
      vecs[2] = '{12'h101, 12'h100, 1'b0};  // sum 0x201: present
      vecs[3] = '{12'h0E8, 12'h0E8, 1'b1};  // between thresholds from IDLE
      vecs[4] = '{12'hFFF, 12'hFFF, 1'b0};  // max sum, 13-bit carry
      vecs[5] = '{12'hFFF, 12'h000, 1'b0};  // unbalanced still enters WAIT
      vecs[6] = '{12'h200, 12'h000, 1'b1};

      rst = 1'b1;
      set_ld(0, 0);
      for (int i = 0; i < 3; i++) step();
      chk("rst_nxt", nxt, 0);
      chk("rst_en_steer", en_steer, 0);
      chk("rst_rider_off", rider_off, 1);

      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         set_ld(vecs[i].l, vecs[i].r);
         step();
         chk($sformatf("vec%0d_rider_off", i), rider_off, vecs[i].exp_off);
         chk($sformatf("vec%0d_en_steer", i), en_steer, 0);
         set_ld(0, 0);
         step();
         chk($sformatf("vec%0d_back_idle", i), rider_off, 1);
      end

      // Balanced rider, hold ~20000 clks in WAIT; nxt cadence observed meanwhile.
      set_ld(12'h180, 12'h180);
      step();
      chk("enter_wait", rider_off, 0);
      for (int i = 0; i < 19999; i++) step();
      chk("no_steer_yet", en_steer, 0);
      chk_rng("nxt_count", nxt_q.size(), 9, 10);
      if (nxt_q.size() > 0) chk("nxt_first", nxt_q[0], NXT_PERIOD);
      for (int i = 1; i < nxt_q.size(); i++)
         chk($sformatf("nxt_period%0d", i), nxt_q[i] - nxt_q[i-1], NXT_PERIOD);

      // Reset mid-WAIT with timer partially counted.
      rst = 1'b1;
      step();
      chk("midrst_rider_off", rider_off, 1);
      chk("midrst_en_steer", en_steer, 0);
      chk("midrst_nxt", nxt, 0);
      rst = 1'b0;
      step();
      chk("reenter_wait", rider_off, 0);

`ifdef FAST_SIM_EN
      wait_steer(40000, n);
      chk_rng("full_wait_after_rst", n, 32767, 32769);

      // Exact diff_big boundary (480*16 == 512*15) is not big.
      set_ld(12'h1F0, 12'h010);
      step();
      chk("diff_edge_keeps_steer", en_steer, 1);
      set_ld(12'h300, 12'h010);
      step();
      chk("unbal_en_steer", en_steer, 0);
      chk("unbal_rider_off", rider_off, 0);
      set_ld(12'h180, 12'h180);
      wait_steer(40000, n);
      chk_rng("fresh_wait", n, 32767, 32769);

      set_ld(12'h0E8, 12'h0E8);
      for (int i = 0; i < 5; i++) step();
      chk("hyst_keeps_steer", en_steer, 1);
      chk("hyst_rider_on", rider_off, 0);
      set_ld(12'h0D0, 12'h0D0);
      step();
      chk("gone_en_steer", en_steer, 0);
      chk("gone_rider_off", rider_off, 1);
`else
      for (int i = 0; i < 2000; i++) step();
      chk("slow_tmr_no_steer", en_steer, 0);
      set_ld(0, 0);
      step();
      chk("gone_rider_off", rider_off, 1);
`endif

      // From IDLE: between thresholds stays off, just above threshold enters.
      set_ld(12'h0E8, 12'h0E8);
      for (int i = 0; i < 5; i++) step();
      chk("idle_hyst_off", rider_off, 1);
      set_ld(12'h101, 12'h100);
      step();
      chk("idle_to_wait", rider_off, 0);
      set_ld(0, 0);
      step();

      // Randomised segments checked by the per-cycle model comparison.
      for (int seg = 0; seg < 150; seg++) begin
         mode = int'($urandom_range(0, 3));
         case (mode)
            0: set_ld(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            1: begin
               base = int'($urandom_range(200, 320));
               set_ld(base + int'($urandom_range(0, 12)), base - int'($urandom_range(0, 12)));
            end
            2: set_ld(int'($urandom_range(0, 600)), int'($urandom_range(0, 600)));
            default: set_ld(int'($urandom_range(0, 4095)), int'($urandom_range(0, 40)));
         endcase
         rst  = ($urandom_range(0, 29) == 0);
         hold = rst ? 1 : int'($urandom_range(1, 20));
         for (int i = 0; i < hold; i++) step();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
